// File: rtl/cnn_mac_pkg.sv
// cnn_mac_pkg: shared widths and helpers for the CNN multiply-accumulate slice.
//   clog2        - ceil(log2(v)), used to size accumulator guard bits
//   acc_width    - accumulator width: product width + guard bits for MAX_LEN
//   sat_signed   - clamps a 64-bit signed value to an out_w-bit signed range
//                  and reports whether clamping happened
// Default widths are exported as localparams for the top and its interface.
package cnn_mac_pkg;

  localparam int A_W_DEF       = 13;
  localparam int B_W_DEF       = 9;
  localparam int NUM_STAGE_DEF = 2;
  localparam int MAX_LEN_DEF   = 256;
  localparam int OUT_W_DEF     = 16;

  // 64-bit carrier for the saturation helper; accumulators must fit in it.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic signed [SAT_W-1:0] val;
    logic                    sat;
  } sat_res_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_width(input int a_w, input int b_w, input int max_len);
    return a_w + b_w + clog2(max_len);
  endfunction

  function automatic sat_res_t sat_signed(input logic signed [SAT_W-1:0] value,
                                          input int out_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t r;
    hi    = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (out_w - 1));
    r.val = value;
    r.sat = 1'b0;
    if (value > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (value < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cnn_mac_pipe_if.sv
// cnn_mac_pipe_if: operand stream in, saturated window sum out.
//   in_valid/in_ready/din0/din1/din_last : beat handshake (producer -> MAC)
//   out_valid/out_ready/dout/dout_sat     : result handshake (MAC -> consumer)
// slave modport is the MAC side; master modport is the producer/consumer side.
interface cnn_mac_pipe_if
  import cnn_mac_pkg::*;
#(
  parameter int A_W   = A_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int OUT_W = OUT_W_DEF
);
  logic                    in_valid;
  logic                    in_ready;
  logic [A_W-1:0]          din0;
  logic signed [B_W-1:0]   din1;
  logic                    din_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] dout;
  logic                    dout_sat;

  modport slave (
    input  in_valid, din0, din1, din_last, out_ready,
    output in_ready, out_valid, dout, dout_sat
  );

  modport master (
    output in_valid, din0, din1, din_last, out_ready,
    input  in_ready, out_valid, dout, dout_sat
  );
endinterface

// File: rtl/cnn_mac_mul_pipe.sv
// cnn_mac_mul_pipe: unsigned(a) x signed(b) multiplier followed by NUM_STAGE
// register stages (1..4) sharing one enable, with valid and last carried
// alongside the product. Data registers have no reset so they can pack into
// DSP pipeline registers; only the control bits are reset.
//   clk, rst_n      : clock, async active-low reset
//   en              : advance all stages
//   in_vld/in_last  : beat qualifiers at the pipe head
//   a, b            : operands (a unsigned, b signed)
//   out_vld/out_last/p : pipe tail
module cnn_mac_mul_pipe #(
  parameter int A_W       = 13,
  parameter int B_W       = 9,
  parameter int NUM_STAGE = 2,
  localparam int P_W      = A_W + B_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_vld,
  input  logic                  in_last,
  input  logic [A_W-1:0]        a,
  input  logic signed [B_W-1:0] b,
  output logic                  out_vld,
  output logic                  out_last,
  output logic signed [P_W-1:0] p
);

  logic [NUM_STAGE-1:0]  vld_pipe_q, vld_pipe_d;
  logic [NUM_STAGE-1:0]  last_pipe_q, last_pipe_d;
  logic signed [P_W-1:0] p_pipe_q [NUM_STAGE];
  logic signed [P_W-1:0] p_pipe_d [NUM_STAGE];
  logic signed [P_W-1:0] a_ext, b_ext, prod;

  // Both operands extended to P_W; the exact product always fits in P_W.
  always_comb begin
    a_ext = $signed({{B_W{1'b0}}, a});
    b_ext = $signed({{A_W{b[B_W-1]}}, b});
    prod  = a_ext * b_ext;
  end

  always_comb begin
    vld_pipe_d  = vld_pipe_q;
    last_pipe_d = last_pipe_q;
    p_pipe_d    = p_pipe_q;
    if (en) begin
      for (int i = NUM_STAGE - 1; i > 0; i--) begin
        vld_pipe_d[i]  = vld_pipe_q[i-1];
        last_pipe_d[i] = last_pipe_q[i-1];
        p_pipe_d[i]    = p_pipe_q[i-1];
      end
      vld_pipe_d[0]  = in_vld;
      last_pipe_d[0] = in_last;
      p_pipe_d[0]    = prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
    end
  end

  always_ff @(posedge clk) begin
    p_pipe_q <= p_pipe_d;
  end

  assign out_vld  = vld_pipe_q[NUM_STAGE-1];
  assign out_last = last_pipe_q[NUM_STAGE-1];
  assign p        = p_pipe_q[NUM_STAGE-1];

endmodule

// File: rtl/cnn_mac_pipe.sv
// cnn_mac_pipe: pipelined multiply-accumulate with window sum saturation.
//   ap_clk, ap_rst_n : clock, async active-low reset (released synchronously)
//   io (slave)       : beat stream in (din0 unsigned, din1 signed, din_last),
//                      saturated window sum out (dout, dout_sat)
// Products travel NUM_STAGE registers, are summed into an ACC_W accumulator
// and, on the window's last beat, saturated into the output register.
// Result is valid NUM_STAGE+1 cycles after the last beat is accepted.
// Optional build macro CNN_MAC_RELU_EN: negative sums output 0 with no
// saturation flag; positive saturation is unchanged.
module cnn_mac_pipe
  import cnn_mac_pkg::*;
#(
  parameter int A_W       = A_W_DEF,
  parameter int B_W       = B_W_DEF,
  parameter int NUM_STAGE = NUM_STAGE_DEF,
  parameter int MAX_LEN   = MAX_LEN_DEF,
  parameter int OUT_W     = OUT_W_DEF
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  cnn_mac_pipe_if.slave io
);

  localparam int P_W   = A_W + B_W;
  localparam int ACC_W = acc_width(A_W, B_W, MAX_LEN);

  // Reset synchronizer: assertion is immediate, release waits two edges.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_sync_q <= '0;
    else           rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  logic                    en;
  logic                    mul_vld, mul_last;
  logic signed [P_W-1:0]   mul_p;

  logic signed [ACC_W-1:0] acc_q, acc_d, acc_next, p_ext;
  logic                    first_q, first_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] dout_q, dout_d;
  logic                    dout_sat_q, dout_sat_d;
  sat_res_t                sat_r;
  logic                    load;

  // A held result with no taker freezes the whole datapath.
  assign en = !(out_valid_q && !io.out_ready);

  cnn_mac_mul_pipe #(
    .A_W      (A_W),
    .B_W      (B_W),
    .NUM_STAGE(NUM_STAGE)
  ) u_mul (
    .clk     (ap_clk),
    .rst_n   (rst_n),
    .en      (en),
    .in_vld  (io.in_valid),
    .in_last (io.din_last),
    .a       (io.din0),
    .b       (io.din1),
    .out_vld (mul_vld),
    .out_last(mul_last),
    .p       (mul_p)
  );

  always_comb begin
    acc_d       = acc_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    dout_sat_d  = dout_sat_q;

    p_ext    = ACC_W'(mul_p);
    acc_next = first_q ? p_ext : acc_q + p_ext;
    sat_r    = sat_signed(SAT_W'(acc_next), OUT_W);
    load     = en && mul_vld && mul_last;

    if (en && mul_vld) begin
      if (mul_last) begin
        first_d = 1'b1;
`ifdef CNN_MAC_RELU_EN
        if (acc_next[ACC_W-1]) begin
          dout_d     = '0;
          dout_sat_d = 1'b0;
        end else begin
          dout_d     = OUT_W'(sat_r.val);
          dout_sat_d = sat_r.sat;
        end
`else
        dout_d     = OUT_W'(sat_r.val);
        dout_sat_d = sat_r.sat;
`endif
      end else begin
        acc_d   = acc_next;
        first_d = 1'b0;
      end
    end

    // A load in the drain cycle wins, giving back-to-back results.
    if (load)                               out_valid_d = 1'b1;
    else if (out_valid_q && io.out_ready)   out_valid_d = 1'b0;
  end

  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      dout_sat_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      dout_sat_q  <= dout_sat_d;
    end
  end

  assign io.in_ready  = en;
  assign io.out_valid = out_valid_q;
  assign io.dout      = dout_q;
  assign io.dout_sat  = dout_sat_q;

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// tb_cnn_mac_pipe: directed stimulus with a result scoreboard for cnn_mac_pipe.
// Expected window sums are modelled in 64-bit arithmetic when each beat is
// accepted and compared when the DUT hands a result over.
module tb_cnn_mac_pipe;

  localparam int NUM_STAGE = 2;
  localparam int OUT_W     = 16;

  typedef struct {
    logic signed [15:0] d;
    logic               s;
  } exp_t;

  logic ap_clk;
  logic ap_rst_n;

  cnn_mac_pipe_if #(.A_W(13), .B_W(9), .OUT_W(OUT_W)) io ();

  cnn_mac_pipe #(
    .A_W(13), .B_W(9), .NUM_STAGE(NUM_STAGE), .MAX_LEN(256), .OUT_W(OUT_W)
  ) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .io      (io.slave)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int     checks = 0;
  int     errors = 0;
  int     n_pushed = 0;
  int     n_popped = 0;
  longint model_sum = 0;
  exp_t   sb[$];
  exp_t   mon_e;

  function automatic exp_t expect_of(input longint s);
    exp_t e;
    if (s > 32767)       begin e.d = 16'sh7fff; e.s = 1'b1; end
    else if (s < -32768) begin e.d = 16'sh8000; e.s = 1'b1; end
    else                 begin e.d = 16'(s);    e.s = 1'b0; end
`ifdef CNN_MAC_RELU_EN
    if (s < 0) begin e.d = '0; e.s = 1'b0; end
`endif
    return e;
  endfunction

  // Scoreboard consumer: a result is taken whenever valid meets ready.
  always @(negedge ap_clk) begin
    if (ap_rst_n && io.out_valid && io.out_ready) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++; $error("FAIL sb_unexpected observed dout=%0d expected no result", io.dout);
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        n_popped++;
        checks++;
        assert (io.dout === mon_e.d) else begin
          errors++; $error("FAIL dout observed=%0d expected=%0d", io.dout, mon_e.d);
        end
        checks++;
        assert (io.dout_sat === mon_e.s) else begin
          errors++; $error("FAIL dout_sat observed=%0b expected=%0b", io.dout_sat, mon_e.s);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Present one beat until accepted; update the model on acceptance.
  task automatic send(input int a, input int b, input bit last);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    io.in_valid = 1'b1;
    io.din0     = a[12:0];
    io.din1     = b[8:0];
    io.din_last = last;
    while (!acc && n < 200) begin
      @(negedge ap_clk);
      acc = io.in_ready;
      @(posedge ap_clk);
      #1;
      n++;
    end
    io.in_valid = 1'b0;
    io.din_last = 1'b0;
    checks++;
    assert (acc) else begin
      errors++; $error("FAIL send_timeout observed=not_accepted expected=accepted");
    end
    if (acc) begin
      model_sum += longint'(a) * longint'(b);
      if (last) begin
        sb.push_back(expect_of(model_sum));
        n_pushed++;
        model_sum = 0;
      end
    end
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n;
    n = 0;
    @(negedge ap_clk);
    while (!io.out_valid && n < max) begin
      @(negedge ap_clk);
      n++;
    end
    chk(tag, 32'(io.out_valid), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  initial begin
    io.in_valid  = 1'b0;
    io.din0      = '0;
    io.din1      = '0;
    io.din_last  = 1'b0;
    io.out_ready = 1'b1;
    ap_rst_n     = 1'b0;

    // Reset state
    idle(3);
    @(negedge ap_clk);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_dout",      32'(io.dout),      32'd0);
    chk("rst_dout_sat",  32'(io.dout_sat),  32'd0);
    chk("rst_in_ready",  32'(io.in_ready),  32'd1);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    idle(3);

    // 1: single-beat window, negative saturation, latency NUM_STAGE+1
    send(8191, -256, 1'b1);
    repeat (NUM_STAGE - 1) @(posedge ap_clk);
    #1;
    chk("lat_early", 32'(io.out_valid), 32'd0);
    @(posedge ap_clk); #1;
    chk("lat_ontime", 32'(io.out_valid), 32'd1);
    idle(3);

    // 2: three-beat window, then a fresh window
    send(100, 3, 1'b0);
    send(200, -2, 1'b0);
    send(5, 7, 1'b1);
    send(10, 10, 1'b1);
    idle(6);

    // positive saturation (sum 36000)
    send(300, 120, 1'b1);
    idle(6);

    // 3: backpressure with two windows queued
    io.out_ready = 1'b0;
    send(100, 3, 1'b0);
    send(200, -2, 1'b0);
    send(5, 7, 1'b1);
    send(10, 10, 1'b1);
    wait_valid("bp_first_valid", 20);
    idle(3);
    @(negedge ap_clk);
    chk("bp_in_ready_low", 32'(io.in_ready), 32'd0);
    chk("bp_held_valid",   32'(io.out_valid), 32'd1);
    @(posedge ap_clk); #1;
    io.out_ready = 1'b1;
    @(negedge ap_clk);
    chk("bp_drain0_valid", 32'(io.out_valid), 32'd1);
    @(negedge ap_clk);
    chk("bp_drain1_valid", 32'(io.out_valid), 32'd1);
    @(negedge ap_clk);
    chk("bp_drained",      32'(io.out_valid), 32'd0);
    idle(2);

    // 4: bubbles inside a window
    send(100, 3, 1'b0);
    idle(3);
    send(200, -2, 1'b0);
    idle(3);
    send(5, 7, 1'b1);
    idle(6);

    // 5: reset mid-window with a result pending
    io.out_ready = 1'b0;
    send(10, 10, 1'b1);
    send(100, 3, 1'b0);
    wait_valid("rstmid_pending", 20);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", 32'(io.out_valid), 32'd0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    sb.delete();
    n_pushed--;
    model_sum = 0;
    io.out_ready = 1'b1;
    idle(3);
    send(5, 7, 1'b1);
    idle(6);

    // Long random-ish window that stays in range (12 beats)
    for (int i = 0; i < 12; i++) send(37 * i + 11, (i % 5) - 2, (i == 11));
    idle(6);

    chk("sb_empty",     32'(sb.size()), 32'd0);
    chk("result_count", 32'(n_popped),  32'(n_pushed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time bound
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
